// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and multiplier state encoding for the alu_64 / alu_seq_mul_64 pair.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_64.sv
// Combinational datapath ALU; the multiplier borrows it for its per-iteration add.
module alu_64
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_mul_64.sv
// Iterative shift-add multiplier (low WIDTH bits of the product) driving an external alu_64.
// Optional early exit when the remaining multiplier is zero: ALU_SEQ_MUL_EARLY_EXIT_EN.
module alu_seq_mul_64
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               early_exit;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    // No set bits left in the multiplier: further iterations cannot change acc.
    assign early_exit = (mplier_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_AND;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (early_exit) begin
                    product_d = acc_q;
                    state_d   = DONE;
                end else begin
                    alu_a    = acc_q;
                    alu_b    = mcand_q;
                    alu_op   = ALU_ADD;
                    if (mplier_q[0]) begin
                        acc_d = alu_result;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // Last iteration: publish the acc including this cycle's add.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_d = acc_d;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    assign product = product_q;

endmodule
